// File: rtl/reg_file_sb.sv
// Multi-entry register file with byte-enable write, two read ports,
// optional write forwarding and a per-register busy scoreboard.
module reg_file_sb #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int AW       = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_en,
  input  logic [AW-1:0]      wr_addr,
  input  logic [WIDTH-1:0]   wr_data,
  input  logic [WIDTH/8-1:0] wr_be,
  input  logic               rsv_en,
  input  logic [AW-1:0]      rsv_addr,
  input  logic [AW-1:0]      rs_addr,
  input  logic [AW-1:0]      rt_addr,
  output logic [WIDTH-1:0]   rs_data,
  output logic [WIDTH-1:0]   rt_data,
  output logic               rs_busy,
  output logic               rt_busy
);

  localparam int          NB      = WIDTH / 8;
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [WIDTH-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;

  logic [WIDTH-1:0] wr_old;
  logic [WIDTH-1:0] wr_merge;
  logic [WIDTH-1:0] rs_old;
  logic [WIDTH-1:0] rt_old;
  logic             rs_bsy;
  logic             rt_bsy;

  logic wr_ok;
  logic rsv_ok;
  logic rs_ok;
  logic rt_ok;
  logic rs_fwd;
  logic rt_fwd;

  // A register is real and writable: in range and not the hardwired zero.
  function automatic logic ok(input logic [AW-1:0] a);
    ok = ({1'b0, a} < DEPTH_W) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  assign wr_ok  = wr_en  & ok(wr_addr);
  assign rsv_ok = rsv_en & ok(rsv_addr);
  assign rs_ok  = ok(rs_addr);
  assign rt_ok  = ok(rt_addr);

  assign rs_fwd = (BYPASS != 0) && wr_ok && (wr_addr == rs_addr);
  assign rt_fwd = (BYPASS != 0) && wr_ok && (wr_addr == rt_addr);

  // Decode-style lookup keeps every index inside the array bounds.
  always_comb begin
    wr_old = '0;
    rs_old = '0;
    rt_old = '0;
    rs_bsy = 1'b0;
    rt_bsy = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (wr_addr == AW'(i)) wr_old = regs_q[i];
      if (rs_addr == AW'(i)) begin
        rs_old = regs_q[i];
        rs_bsy = busy_q[i];
      end
      if (rt_addr == AW'(i)) begin
        rt_old = regs_q[i];
        rt_bsy = busy_q[i];
      end
    end
  end

  // Byte-merge of incoming data over the stored word being written.
  always_comb begin
    wr_merge = wr_old;
    for (int b = 0; b < NB; b++) begin
      if (wr_be[b]) wr_merge[8*b +: 8] = wr_data[8*b +: 8];
    end
  end

  // Next state: write clears busy, a reserve in the same cycle wins.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (wr_ok && (wr_addr == AW'(i))) begin
        regs_d[i] = wr_merge;
        busy_d[i] = 1'b0;
      end
      if (rsv_ok && (rsv_addr == AW'(i))) begin
        busy_d[i] = 1'b1;
      end
    end
  end

  // State update with synchronous active-low reset overriding all ports.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  assign rs_data = !rs_ok ? '0 : (rs_fwd ? wr_merge : rs_old);
  assign rt_data = !rt_ok ? '0 : (rt_fwd ? wr_merge : rt_old);
  assign rs_busy = rs_ok & ~rs_fwd & rs_bsy;
  assign rt_busy = rt_ok & ~rt_fwd & rt_bsy;

endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: two instances (bypass/full depth and
// no-bypass/DEPTH=24) driven in lockstep against a behavioural model.
module tb_reg_file_sb;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_be;
  logic        rsv_en;
  logic [4:0]  rsv_addr;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;

  logic [31:0] a_rs_data, a_rt_data, b_rs_data, b_rt_data;
  logic        a_rs_busy, a_rt_busy, b_rs_busy, b_rt_busy;

  always #5 clk = ~clk;

  reg_file_sb u_a (
    .clk(clk), .reset(reset),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rs_data(a_rs_data), .rt_data(a_rt_data),
    .rs_busy(a_rs_busy), .rt_busy(a_rt_busy)
  );

  reg_file_sb #(.DEPTH(24), .BYPASS(0)) u_b (
    .clk(clk), .reset(reset),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rs_data(b_rs_data), .rt_data(b_rt_data),
    .rs_busy(b_rs_busy), .rt_busy(b_rt_busy)
  );

  // Reference model: plain arrays, one set per instance.
  logic [31:0] m_regs [2][32];
  logic        m_busy [2][32];
  int          depth  [2] = '{32, 24};
  bit          byp    [2] = '{1'b1, 1'b0};

  int    n_chk  = 0;
  int    n_pass = 0;
  string phase  = "init";

  function automatic bit okm(int k, logic [4:0] a);
    return (int'(a) < depth[k]) && (a != 5'd0);
  endfunction

  function automatic logic [31:0] mrg(int k);
    logic [31:0] v;
    v = m_regs[k][wr_addr];
    for (int b = 0; b < 4; b++)
      if (wr_be[b]) v[8*b +: 8] = wr_data[8*b +: 8];
    return v;
  endfunction

  function automatic bit fwd(int k, logic [4:0] a);
    return byp[k] && wr_en && (wr_addr == a) && okm(k, a);
  endfunction

  function automatic logic [31:0] exp_rd(int k, logic [4:0] a);
    if (!okm(k, a)) return 32'd0;
    if (fwd(k, a)) return mrg(k);
    return m_regs[k][a];
  endfunction

  function automatic logic exp_bsy(int k, logic [4:0] a);
    return okm(k, a) && !fwd(k, a) && m_busy[k][a];
  endfunction

  task automatic model_edge();
    logic [31:0] nv [2];
    for (int k = 0; k < 2; k++) nv[k] = mrg(k);
    for (int k = 0; k < 2; k++) begin
      if (!reset) begin
        for (int i = 0; i < 32; i++) begin
          m_regs[k][i] = 32'd0;
          m_busy[k][i] = 1'b0;
        end
      end else begin
        if (wr_en && okm(k, wr_addr)) begin
          m_regs[k][wr_addr] = nv[k];
          m_busy[k][wr_addr] = 1'b0;
        end
        if (rsv_en && okm(k, rsv_addr)) m_busy[k][rsv_addr] = 1'b1;
      end
    end
  endtask

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s/%s observed=%h expected=%h", phase, tag, obs, exp);
  endtask

  task automatic check_model();
    check("a.rs_data", a_rs_data, exp_rd(0, rs_addr));
    check("a.rt_data", a_rt_data, exp_rd(0, rt_addr));
    check("a.rs_busy", {31'd0, a_rs_busy}, {31'd0, exp_bsy(0, rs_addr)});
    check("a.rt_busy", {31'd0, a_rt_busy}, {31'd0, exp_bsy(0, rt_addr)});
    check("b.rs_data", b_rs_data, exp_rd(1, rs_addr));
    check("b.rt_data", b_rt_data, exp_rd(1, rt_addr));
    check("b.rs_busy", {31'd0, b_rs_busy}, {31'd0, exp_bsy(1, rs_addr)});
    check("b.rt_busy", {31'd0, b_rt_busy}, {31'd0, exp_bsy(1, rt_addr)});
  endtask

  // Called at the negedge after inputs are applied.
  task automatic settle();
    #1;
    check_model();
  endtask

  task automatic edge_adv();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic step();
    settle();
    edge_adv();
  endtask

  task automatic idle();
    reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_be = '0;
    rsv_en = 1'b0; rsv_addr = '0; rs_addr = '0; rt_addr = '0;
  endtask

  task automatic wr(logic [4:0] a, logic [31:0] d, logic [3:0] be);
    idle();
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
    rs_addr = a; rt_addr = a;
    step();
  endtask

  task automatic rd(logic [4:0] a, logic [4:0] b);
    idle();
    rs_addr = a; rt_addr = b;
    settle();
  endtask

  initial begin
    idle();
    reset = 1'b0;
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 32; i++) begin
        m_regs[k][i] = 32'd0;
        m_busy[k][i] = 1'b0;
      end
    @(posedge clk);
    @(negedge clk);

    phase = "reset";
    rd(5'd2, 5'd9);
    check("rst.rs_data", a_rs_data, 32'd0);
    check("rst.rs_busy", {31'd0, a_rs_busy}, 32'd0);
    edge_adv();
    wr(5'd2, 32'd88, 4'hF);
    idle();
    reset = 1'b0; wr_en = 1'b1; wr_addr = 5'd2; wr_data = 32'd99;
    wr_be = 4'hF; rsv_en = 1'b1; rsv_addr = 5'd2;
    edge_adv();
    rd(5'd2, 5'd2);
    check("rst.r2", a_rs_data, 32'd0);
    check("rst.r2_busy", {31'd0, a_rs_busy}, 32'd0);
    edge_adv();

    phase = "byte_en";
    wr(5'd4, 32'h11223344, 4'hF);
    wr(5'd4, 32'hAABBCCDD, 4'b0101);
    rd(5'd4, 5'd4);
    check("be.r4", a_rs_data, 32'h11BB33DD);
    check("be.r4b", b_rt_data, 32'h11BB33DD);
    edge_adv();
    wr(5'd4, 32'hFFFFFFFF, 4'h0);
    rd(5'd4, 5'd4);
    check("be0.r4", a_rs_data, 32'h11BB33DD);
    edge_adv();

    phase = "zero_oor";
    wr(5'd0, 32'd45, 4'hF);
    rd(5'd0, 5'd0);
    check("r0", a_rs_data, 32'd0);
    edge_adv();
    wr(5'd30, 32'd77, 4'hF);
    rd(5'd30, 5'd4);
    check("b.r30", b_rs_data, 32'd0);
    check("b.r4_kept", b_rt_data, 32'h11BB33DD);
    check("a.r30", a_rs_data, 32'd77);
    edge_adv();

    phase = "forward";
    wr(5'd3, 32'd7, 4'hF);
    idle();
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'd67; wr_be = 4'hF;
    rs_addr = 5'd3; rt_addr = 5'd3;
    settle();
    check("fwd.a.rs", a_rs_data, 32'd67);
    check("fwd.a.rt", a_rt_data, 32'd67);
    check("fwd.b.rs", b_rs_data, 32'd7);
    edge_adv();
    rd(5'd3, 5'd3);
    check("fwd.b.after", b_rs_data, 32'd67);
    edge_adv();

    phase = "scoreboard";
    idle(); rsv_en = 1'b1; rsv_addr = 5'd5; rs_addr = 5'd5;
    settle();
    check("rsv.same_cycle", {31'd0, a_rs_busy}, 32'd0);
    edge_adv();
    rd(5'd5, 5'd5);
    check("rsv.a", {31'd0, a_rs_busy}, 32'd1);
    check("rsv.b", {31'd0, b_rt_busy}, 32'd1);
    edge_adv();
    idle(); wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'd12; wr_be = 4'hF;
    rs_addr = 5'd5;
    settle();
    check("wb.a_busy", {31'd0, a_rs_busy}, 32'd0);
    check("wb.b_busy", {31'd0, b_rs_busy}, 32'd1);
    edge_adv();
    rd(5'd5, 5'd5);
    check("wb.b_after", {31'd0, b_rs_busy}, 32'd0);
    edge_adv();
    wr(5'd5, 32'd3, 4'hF);
    idle(); wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'd12; wr_be = 4'hF;
    rsv_en = 1'b1; rsv_addr = 5'd5;
    step();
    rd(5'd5, 5'd5);
    check("both.busy", {31'd0, a_rs_busy}, 32'd1);
    check("both.data", a_rs_data, 32'd12);
    edge_adv();
    idle(); rsv_en = 1'b1; rsv_addr = 5'd5;
    step();
    wr(5'd5, 32'd12, 4'h0);
    rd(5'd5, 5'd5);
    check("rersv.cleared", {31'd0, b_rs_busy}, 32'd0);
    edge_adv();

    phase = "disabled_wr";
    wr(5'd4, 32'd10, 4'hF);
    idle(); rsv_en = 1'b1; rsv_addr = 5'd4;
    step();
    idle(); wr_addr = 5'd4; wr_data = 32'd96; wr_be = 4'hF; rs_addr = 5'd4;
    step();
    rd(5'd4, 5'd4);
    check("dis.data", a_rs_data, 32'd10);
    check("dis.busy", {31'd0, a_rs_busy}, 32'd1);
    edge_adv();

    phase = "random";
    for (int n = 0; n < 600; n++) begin
      reset    = ($urandom_range(0, 59) != 0);
      wr_en    = $urandom_range(0, 1);
      wr_addr  = 5'($urandom_range(0, 31));
      wr_data  = $urandom;
      wr_be    = 4'($urandom_range(0, 15));
      rsv_en   = ($urandom_range(0, 2) == 0);
      rsv_addr = ($urandom_range(0, 3) == 0) ? wr_addr
                                             : 5'($urandom_range(0, 31));
      rs_addr  = ($urandom_range(0, 3) == 0) ? wr_addr
                                             : 5'($urandom_range(0, 31));
      rt_addr  = ($urandom_range(0, 3) == 0) ? rsv_addr
                                             : 5'($urandom_range(0, 31));
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- Parametrised successor to the single register block: a multi-entry register file.
- One write port with byte enables.
- Two combinational read ports with optional write-to-read forwarding.
- Per-register busy scoreboard, so a pipelined datapath can reserve a destination at issue and detect read-after-write hazards until writeback.
- Sits between decode (read and reserve) and writeback (write).

Parameters:
- WIDTH, 32, data width in bits; must be a multiple of 8.
- DEPTH, 32, number of registers; 2..32, need not be a power of two.
- AW, 5, address width; must satisfy 2**AW >= DEPTH.
- ZERO_REG, 1, 1 = register 0 reads 0, ignores writes, and is never busy.
- BYPASS, 1, 1 = same-cycle write data is forwarded to the read ports.

Ports:
- clk  in  1  clock; all state changes on posedge.
- reset  in  1  synchronous, active-low reset; sampled on posedge clk.
- wr_en  in  1  write strobe.
- wr_addr  in  AW  write register number.
- wr_data  in  WIDTH  write data.
- wr_be  in  WIDTH/8  byte enables; bit i covers wr_data[8i+7:8i].
- rsv_en  in  1  reserve strobe; marks rsv_addr busy.
- rsv_addr  in  AW  register to reserve.
- rs_addr  in  AW  read port A address.
- rt_addr  in  AW  read port B address.
- rs_data  out  WIDTH  read port A data (combinational).
- rt_data  out  WIDTH  read port B data (combinational).
- rs_busy  out  1  port A source has a pending producer.
- rt_busy  out  1  port B source has a pending producer.

Behaviour:
- Reset: posedge with reset==0 clears every register to 0 and every busy bit to 0.
  - Reset overrides wr_en and rsv_en in the same cycle.
  - Reset mid-sequence discards all pending reservations.
  - After reset, rs_data = rt_data = 0 and rs_busy = rt_busy = 0.
- Write:
  - Occurs at posedge when reset==1 and wr_en==1.
  - Each byte i with wr_be[i]==1 takes wr_data byte i; other bytes keep their value.
  - wr_be==0 with wr_en==1 changes no data but still clears busy (see Scoreboard).
  - Ignored when wr_addr >= DEPTH, or when wr_addr==0 and ZERO_REG==1.
- Read: combinational, zero latency.
  - Address >= DEPTH reads 0.
  - Address 0 with ZERO_REG==1 reads 0.
  - Both ports may address the same register.
- Forwarding, BYPASS==1:
  - Applies when wr_en==1, wr_addr==read address, and the address is writable.
  - Read data is then the merged value: wr_data bytes where wr_be=1, stored bytes elsewhere.
  - Result equals the value the register holds after the edge.
- Forwarding, BYPASS==0: read ports show the stored value; new data is visible from the cycle after the write.
- Scoreboard: one busy bit per register, updated at posedge when reset==1.
  - rsv_en==1 sets busy[rsv_addr].
  - wr_en==1 clears busy[wr_addr], regardless of wr_be.
  - rsv_en and wr_en to the same address in the same cycle: the reserve wins and busy ends set (a new producer is issued).
  - Reserve and write to different addresses: both take effect.
  - Reserve of address 0 with ZERO_REG==1, or of an address >= DEPTH: ignored.
  - Re-reserving an already-busy register: stays busy; no count is kept, so a single write clears it.
- Busy outputs:
  - rs_busy = busy[rs_addr], except forced to 0 when BYPASS==1, wr_en==1, wr_addr==rs_addr and the address is writable.
  - rt_busy follows the same rule for rt_addr.
  - Address 0 (ZERO_REG==1) and addresses >= DEPTH always report not busy.
- No other internal state; no extra latency anywhere.

Test Plan:
- Reset: write 88 to r2 with reset=1, then hold reset=0 for one edge while wr_en=1, wr_addr=2, wr_data=99 → after the edge rs_addr=2 reads 0 and rs_busy=0.
- Byte enables: write 32'h11223344 to r4 with be=4'hF, then 32'hAABBCCDD with be=4'b0101 → r4 reads 32'h11BB33DD; be=0 write leaves it unchanged.
- Zero and out-of-range registers: write 45 to r0 → reads 0. With DEPTH=24, write to r30 → rs_addr=30 reads 0, and no other register changes.
- Forwarding:
  - BYPASS=1, r3 holds 7; in the same cycle wr_en=1, wr_addr=3, wr_data=67, rs_addr=rt_addr=3 → both ports show 67 before the edge.
  - BYPASS=0, same stimulus → ports show 7, then 67 after the edge.
- Scoreboard:
  - Reserve r5 → rs_busy=1 from the next cycle.
  - Write r5=12 → with BYPASS=1 rs_busy=0 during the write cycle; with BYPASS=0 it stays 1 during the write cycle, then 0 after the edge.
  - Simultaneous reserve and write of r5 → busy remains 1 and data becomes 12.
- Disabled write: wr_en=0, wr_addr=4, wr_data=96 → r4 keeps its prior value (e.g. 10), and its busy bit is unchanged.
